// File: rtl/bfs_apply_ctrl_pkg.sv
// Shared types and default widths for the BFS apply/gather sequencer and its gather datapath.
package bfs_pkg;

  localparam int unsigned DEF_NODEID_WIDTH = 32;
  localparam int unsigned DEF_LEVEL_WIDTH  = 32;
  localparam int unsigned DEF_ADDR_WIDTH   = 10;
  localparam int unsigned DEF_NUM_NODES    = 1024;
  localparam int unsigned DEF_CNT_WIDTH    = 32;

  // Parent value stored for a node that has never been reached.
  localparam int unsigned UNVISITED_PARENT = 0;

  typedef enum logic [1:0] {
    StIdle,
    StRdWait,
    StGather,
    StEmit
  } state_e;

endpackage

// File: rtl/bfs_apply_ctrl_if.sv
// Bundle of message, state-memory, gather, update and statistics signals around bfs_apply_ctrl.
interface bfs_apply_ctrl_if
  import bfs_pkg::*;
#(
  parameter int unsigned NODEID_WIDTH = DEF_NODEID_WIDTH,
  parameter int unsigned LEVEL_WIDTH  = DEF_LEVEL_WIDTH,
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH
) ();

  logic                    msg_valid;
  logic                    msg_ack;
  logic [NODEID_WIDTH-1:0] msg_nodeid;
  logic [NODEID_WIDTH-1:0] msg_sender;
  logic [LEVEL_WIDTH-1:0]  msg_level;

  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [NODEID_WIDTH-1:0] rd_parent;
  logic                    rd_active;

  logic                    g_valid_in;
  logic                    g_state_ack;
  logic [NODEID_WIDTH-1:0] g_nodeid;
  logic [NODEID_WIDTH-1:0] g_sender;
  logic [LEVEL_WIDTH-1:0]  g_level;
  logic [NODEID_WIDTH-1:0] g_state_parent;
  logic                    g_state_active;
  logic                    g_state_valid;
  logic [NODEID_WIDTH-1:0] g_nodeid_out;
  logic [NODEID_WIDTH-1:0] g_parent_out;
  logic                    g_active_out;

  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [NODEID_WIDTH-1:0] wr_parent;
  logic                    wr_active;

  logic                    upd_valid;
  logic                    upd_ack;
  logic [NODEID_WIDTH-1:0] upd_nodeid;
  logic [LEVEL_WIDTH-1:0]  upd_level;

  logic                    busy;
  logic [CNT_WIDTH-1:0]    cnt_msgs;
  logic [CNT_WIDTH-1:0]    cnt_dropped;

  modport master (
    input  msg_valid, msg_nodeid, msg_sender, msg_level,
    output msg_ack,
    output rd_en, rd_addr,
    input  rd_parent, rd_active,
    output g_valid_in, g_state_ack, g_nodeid, g_sender, g_level, g_state_parent, g_state_active,
    input  g_state_valid, g_nodeid_out, g_parent_out, g_active_out,
    output wr_en, wr_addr, wr_parent, wr_active,
    output upd_valid, upd_nodeid, upd_level,
    input  upd_ack,
    output busy, cnt_msgs, cnt_dropped
  );

  modport slave (
    output msg_valid, msg_nodeid, msg_sender, msg_level,
    input  msg_ack,
    input  rd_en, rd_addr,
    output rd_parent, rd_active,
    input  g_valid_in, g_state_ack, g_nodeid, g_sender, g_level, g_state_parent, g_state_active,
    output g_state_valid, g_nodeid_out, g_parent_out, g_active_out,
    input  wr_en, wr_addr, wr_parent, wr_active,
    input  upd_valid, upd_nodeid, upd_level,
    output upd_ack,
    input  busy, cnt_msgs, cnt_dropped
  );

endinterface

// File: rtl/bfs_sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping; clear has priority.
module bfs_sat_counter #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_clear,
  input  logic                 i_inc,
  output logic [CNT_WIDTH-1:0] o_count
);

  logic [CNT_WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + CNT_WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/bfs_apply_ctrl.sv
// BFS apply-stage sequencer: read node state, run it through gather, write back, announce new visits.
module bfs_apply_ctrl
  import bfs_pkg::*;
#(
  parameter int unsigned NODEID_WIDTH = DEF_NODEID_WIDTH,
  parameter int unsigned LEVEL_WIDTH  = DEF_LEVEL_WIDTH,
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned NUM_NODES    = DEF_NUM_NODES,
  parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  bfs_apply_ctrl_if.master bus
);

  state_e                  r_state, w_state_next;
  logic [NODEID_WIDTH-1:0] r_nodeid, r_sender, r_parent, r_wr_parent, r_upd_nodeid;
  logic [LEVEL_WIDTH-1:0]  r_level, r_upd_level;
  logic                    r_active, r_wr_active;

  logic w_in_range, w_msg_ack, w_rd_en, w_gather, w_wr_en, w_upd_valid, w_drop, w_load_upd;

  assign w_in_range = bus.msg_nodeid < NODEID_WIDTH'(NUM_NODES);

  always_comb begin
    w_state_next = r_state;
    w_msg_ack    = 1'b0;
    w_rd_en      = 1'b0;
    w_gather     = 1'b0;
    w_wr_en      = 1'b0;
    w_upd_valid  = 1'b0;
    w_drop       = 1'b0;
    w_load_upd   = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_msg_ack = 1'b1;
        if (bus.msg_valid) begin
          if (w_in_range) begin
            w_rd_en      = 1'b1;
            w_state_next = StRdWait;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      StRdWait: w_state_next = StGather;
      StGather: begin
        w_gather     = 1'b1;
        w_state_next = StIdle;
        // Without state_valid the gather result is unusable: drop it and write nothing.
        if (bus.g_state_valid) begin
          w_wr_en = 1'b1;
          if (r_parent == NODEID_WIDTH'(UNVISITED_PARENT)) begin
            w_load_upd   = 1'b1;
            w_state_next = StEmit;
          end
        end
      end
      StEmit: begin
        w_upd_valid = 1'b1;
        if (bus.upd_ack) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
    // Reset aborts whatever is in flight, including the write and the update.
    if (sys_rst) begin
      w_state_next = StIdle;
      w_msg_ack    = 1'b0;
      w_rd_en      = 1'b0;
      w_gather     = 1'b0;
      w_wr_en      = 1'b0;
      w_upd_valid  = 1'b0;
      w_drop       = 1'b0;
      w_load_upd   = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state      <= StIdle;
      r_nodeid     <= '0;
      r_sender     <= '0;
      r_level      <= '0;
      r_parent     <= '0;
      r_active     <= 1'b0;
      r_wr_parent  <= '0;
      r_wr_active  <= 1'b0;
      r_upd_nodeid <= '0;
      r_upd_level  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_rd_en) begin
        r_nodeid <= bus.msg_nodeid;
        r_sender <= bus.msg_sender;
        r_level  <= bus.msg_level;
      end
      if (r_state == StRdWait) begin
        r_parent <= bus.rd_parent;
        r_active <= bus.rd_active;
      end
      if (w_wr_en) begin
        r_wr_parent <= bus.g_parent_out;
        r_wr_active <= bus.g_active_out;
      end
      if (w_load_upd) begin
        r_upd_nodeid <= r_nodeid;
        r_upd_level  <= r_level + LEVEL_WIDTH'(1);
      end
    end
  end

  assign bus.msg_ack        = w_msg_ack;
  assign bus.rd_en          = w_rd_en;
  assign bus.rd_addr        = bus.msg_nodeid[ADDR_WIDTH-1:0];
  assign bus.g_valid_in     = w_gather;
  assign bus.g_state_ack    = w_gather;
  assign bus.g_nodeid       = r_nodeid;
  assign bus.g_sender       = r_sender;
  assign bus.g_level        = r_level;
  assign bus.g_state_parent = r_parent;
  assign bus.g_state_active = r_active;
  assign bus.wr_en          = w_wr_en;
  assign bus.wr_addr        = r_nodeid[ADDR_WIDTH-1:0];
  // Gather is combinational on registered inputs, so its result is stable throughout GATHER.
  assign bus.wr_parent      = (r_state == StGather) ? bus.g_parent_out : r_wr_parent;
  assign bus.wr_active      = (r_state == StGather) ? bus.g_active_out : r_wr_active;
  assign bus.upd_valid      = w_upd_valid;
  assign bus.upd_nodeid     = r_upd_nodeid;
  assign bus.upd_level      = r_upd_level;
  assign bus.busy           = (r_state != StIdle) && !sys_rst;

  bfs_sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_cnt_msgs (
    .i_clk  (sys_clk),
    .i_clear(sys_rst),
    .i_inc  (w_wr_en),
    .o_count(bus.cnt_msgs)
  );

  bfs_sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_cnt_dropped (
    .i_clk  (sys_clk),
    .i_clear(sys_rst),
    .i_inc  (w_drop),
    .o_count(bus.cnt_dropped)
  );

endmodule

// File: tb/tb_bfs_apply_ctrl.sv
// Bench for bfs_apply_ctrl with a node-state memory model, a gather model and a write/update scoreboard.
module tb_bfs_apply_ctrl;
  import bfs_pkg::*;

  localparam int unsigned NW = 32;
  localparam int unsigned LW = 32;
  localparam int unsigned AW = 10;
  localparam int unsigned NN = 1024;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [NW-1:0] parent;
    logic          active;
  } wr_exp_t;

  typedef struct packed {
    logic [NW-1:0] nodeid;
    logic [LW-1:0] level;
  } upd_exp_t;

  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  bfs_apply_ctrl_if bus ();

  bfs_apply_ctrl dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_msgs = 0;
  int exp_drops = 0;

  wr_exp_t  wq[$];
  upd_exp_t uq[$];

  logic [NW-1:0] mem_parent [NN];
  logic          mem_active [NN];

  // Node-state memory: one-cycle read latency, write on the strobe.
  always @(posedge sys_clk) begin
    if (bus.rd_en) begin
      bus.rd_parent <= mem_parent[bus.rd_addr];
      bus.rd_active <= mem_active[bus.rd_addr];
    end
    if (bus.wr_en) begin
      mem_parent[bus.wr_addr] = bus.wr_parent;
      mem_active[bus.wr_addr] = bus.wr_active;
    end
  end

  // Gather: an unvisited node takes the sender as parent and becomes active.
  always_comb begin
    bus.g_state_valid = bus.g_valid_in;
    bus.g_nodeid_out  = bus.g_nodeid;
    if (bus.g_state_parent == '0) begin
      bus.g_parent_out = bus.g_sender;
      bus.g_active_out = 1'b1;
    end else begin
      bus.g_parent_out = bus.g_state_parent;
      bus.g_active_out = bus.g_state_active;
    end
  end

  always @(negedge sys_clk) begin
    wr_exp_t  we;
    upd_exp_t ue;
    if (bus.wr_en) begin
      n_checks++;
      if (wq.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got addr=%0d parent=%0d active=%0d, required no write",
                 bus.wr_addr, bus.wr_parent, bus.wr_active);
      end else begin
        we = wq.pop_front();
        if ({bus.wr_addr, bus.wr_parent, bus.wr_active} !== we) begin
          n_fail++;
          $display("FAIL wr_data: got addr=%0d parent=%0d active=%0d, required %0d/%0d/%0d",
                   bus.wr_addr, bus.wr_parent, bus.wr_active, we.addr, we.parent, we.active);
        end
      end
    end
    if (bus.upd_valid && bus.upd_ack) begin
      n_checks++;
      if (uq.size() == 0) begin
        n_fail++;
        $display("FAIL upd_unexpected: got node=%0d level=%0d, required no update",
                 bus.upd_nodeid, bus.upd_level);
      end else begin
        ue = uq.pop_front();
        if ({bus.upd_nodeid, bus.upd_level} !== ue) begin
          n_fail++;
          $display("FAIL upd_data: got node=%0d level=%0d, required %0d/%0d",
                   bus.upd_nodeid, bus.upd_level, ue.nodeid, ue.level);
        end
      end
    end
  end

  task automatic drive_msg(input logic [NW-1:0] node, input logic [NW-1:0] sender,
                           input logic [LW-1:0] level);
    bus.msg_valid  = 1'b1;
    bus.msg_nodeid = node;
    bus.msg_sender = sender;
    bus.msg_level  = level;
  endtask

  // Push the write (and update, for a first visit) that a correct controller must produce.
  task automatic expect_msg(input logic [NW-1:0] node, input logic [NW-1:0] sender,
                            input logic [LW-1:0] level);
    logic [AW-1:0] a;
    upd_exp_t      ue;
    a = node[AW-1:0];
    if (mem_parent[a] == '0) begin
      wq.push_back('{addr: a, parent: sender, active: 1'b1});
      ue.nodeid = node;
      ue.level  = LW'(level + LW'(1));
      uq.push_back(ue);
    end else begin
      wq.push_back('{addr: a, parent: mem_parent[a], active: mem_active[a]});
    end
    exp_msgs++;
  endtask

  // Runs from RD_WAIT until back in IDLE, acknowledging any update; ends at posedge+1.
  task automatic finish_msg();
    int t;
    bit done;
    t = 0;
    done = 1'b0;
    while (!done && t < 20) begin
      @(negedge sys_clk);
      t++;
      if (bus.upd_valid) begin
        @(posedge sys_clk); #1;
        bus.upd_ack = 1'b1;
        @(posedge sys_clk); #1;
        bus.upd_ack = 1'b0;
        done = 1'b1;
      end else if (!bus.busy) begin
        @(posedge sys_clk); #1;
        done = 1'b1;
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL finish_timeout: got busy=%0b after %0d cycles, required idle", bus.busy, t);
    end
  endtask

  task automatic do_msg(input logic [NW-1:0] node, input logic [NW-1:0] sender,
                        input logic [LW-1:0] level);
    int t;
    if (node < NN) expect_msg(node, sender, level);
    else exp_drops++;
    drive_msg(node, sender, level);
    t = 0;
    @(negedge sys_clk);
    while (!bus.msg_ack && t < 20) begin
      @(negedge sys_clk);
      t++;
    end
    n_checks++;
    if (!bus.msg_ack) begin
      n_fail++;
      $display("FAIL accept_timeout: got msg_ack=0 for node %0d, required 1", node);
    end
    @(posedge sys_clk); #1;
    bus.msg_valid = 1'b0;
    if (node < NN) finish_msg();
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    n_checks++;
    if ({bus.msg_ack, bus.rd_en, bus.busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_strobes: got ack/rd/busy=%b, required 000",
               {bus.msg_ack, bus.rd_en, bus.busy});
    end
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    n_checks++;
    if ({bus.wr_en, bus.upd_valid, bus.g_valid_in, bus.g_state_ack, bus.busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got wr/upd/gv/ga/busy=%b, required 00000",
               {bus.wr_en, bus.upd_valid, bus.g_valid_in, bus.g_state_ack, bus.busy});
    end
    n_checks++;
    if (bus.cnt_msgs !== '0 || bus.cnt_dropped !== '0) begin
      n_fail++;
      $display("FAIL reset_counters: got msgs=%0d dropped=%0d, required 0/0",
               bus.cnt_msgs, bus.cnt_dropped);
    end
    n_checks++;
    if (bus.msg_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ack: got msg_ack=%b, required 1", bus.msg_ack);
    end
    @(posedge sys_clk); #1;
  endtask

  task automatic test_first_visit();
    mem_parent[5] = '0;
    mem_active[5] = 1'b0;
    wq.push_back('{addr: 10'd5, parent: 32'd3, active: 1'b1});
    uq.push_back('{nodeid: 32'd5, level: 32'd3});
    exp_msgs++;
    drive_msg(32'd5, 32'd3, 32'd2);
    @(negedge sys_clk);
    n_checks++;
    if ({bus.msg_ack, bus.rd_en} !== 2'b11 || bus.rd_addr !== 10'd5) begin
      n_fail++;
      $display("FAIL fv_read: got ack=%b rd_en=%b addr=%0d, required 1/1/5",
               bus.msg_ack, bus.rd_en, bus.rd_addr);
    end
    @(posedge sys_clk); #1;
    bus.msg_valid = 1'b0;
    @(negedge sys_clk);
    n_checks++;
    if ({bus.busy, bus.msg_ack, bus.rd_en} !== 3'b100) begin
      n_fail++;
      $display("FAIL fv_rdwait: got busy/ack/rd=%b, required 100",
               {bus.busy, bus.msg_ack, bus.rd_en});
    end
    @(negedge sys_clk);
    n_checks++;
    if ({bus.g_valid_in, bus.g_state_ack, bus.wr_en} !== 3'b111 || bus.g_sender !== 32'd3 ||
        bus.g_level !== 32'd2 || bus.g_state_parent !== 32'd0) begin
      n_fail++;
      $display("FAIL fv_gather: got gv/ga/wr=%b sender=%0d level=%0d parent=%0d, required 111/3/2/0",
               {bus.g_valid_in, bus.g_state_ack, bus.wr_en}, bus.g_sender, bus.g_level,
               bus.g_state_parent);
    end
    @(posedge sys_clk); #1;
    bus.upd_ack = 1'b1;
    @(negedge sys_clk);
    n_checks++;
    if (bus.upd_valid !== 1'b1 || bus.msg_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL fv_emit: got upd_valid=%b msg_ack=%b, required 1/0",
               bus.upd_valid, bus.msg_ack);
    end
    @(posedge sys_clk); #1;
    bus.upd_ack = 1'b0;
    @(negedge sys_clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.upd_valid !== 1'b0 || bus.cnt_msgs !== 32'd1) begin
      n_fail++;
      $display("FAIL fv_done: got busy=%b upd=%b cnt_msgs=%0d, required 0/0/1",
               bus.busy, bus.upd_valid, bus.cnt_msgs);
    end
    @(posedge sys_clk); #1;
  endtask

  task automatic test_revisit();
    mem_parent[5] = 32'd3;
    mem_active[5] = 1'b0;
    wq.push_back('{addr: 10'd5, parent: 32'd3, active: 1'b0});
    exp_msgs++;
    drive_msg(32'd5, 32'd7, 32'd4);
    @(posedge sys_clk); #1;
    bus.msg_valid = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    n_checks++;
    if (bus.wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL rv_write: got wr_en=%b in cycle 2, required 1", bus.wr_en);
    end
    @(negedge sys_clk);
    n_checks++;
    if ({bus.busy, bus.upd_valid, bus.msg_ack} !== 3'b001 || bus.cnt_msgs !== 32'd2) begin
      n_fail++;
      $display("FAIL rv_idle: got busy/upd/ack=%b cnt_msgs=%0d, required 001/2",
               {bus.busy, bus.upd_valid, bus.msg_ack}, bus.cnt_msgs);
    end
    @(posedge sys_clk); #1;
  endtask

  task automatic test_drop();
    exp_drops++;
    drive_msg(32'd1024, 32'd1, 32'd1);
    @(negedge sys_clk);
    n_checks++;
    if (bus.msg_ack !== 1'b1 || bus.rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_ack: got ack=%b rd_en=%b, required 1/0", bus.msg_ack, bus.rd_en);
    end
    @(posedge sys_clk); #1;
    bus.msg_valid = 1'b0;
    @(negedge sys_clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.cnt_dropped !== 32'd1 || bus.cnt_msgs !== 32'd2) begin
      n_fail++;
      $display("FAIL drop_cnt: got busy=%b dropped=%0d msgs=%0d, required 0/1/2",
               bus.busy, bus.cnt_dropped, bus.cnt_msgs);
    end
    @(posedge sys_clk); #1;
  endtask

  task automatic test_emit_hold();
    mem_parent[9]  = '0;
    mem_active[9]  = 1'b0;
    mem_parent[11] = '0;
    mem_active[11] = 1'b0;
    wq.push_back('{addr: 10'd9, parent: 32'd4, active: 1'b1});
    uq.push_back('{nodeid: 32'd9, level: 32'd7});
    exp_msgs++;
    drive_msg(32'd9, 32'd4, 32'd6);
    @(posedge sys_clk); #1;
    drive_msg(32'd11, 32'd2, 32'd1);
    repeat (2) begin
      @(posedge sys_clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      n_checks++;
      if (bus.upd_valid !== 1'b1 || bus.upd_nodeid !== 32'd9 || bus.upd_level !== 32'd7 ||
          bus.msg_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_%0d: got upd=%b node=%0d level=%0d ack=%b, required 1/9/7/0",
                 i, bus.upd_valid, bus.upd_nodeid, bus.upd_level, bus.msg_ack);
      end
      @(posedge sys_clk); #1;
    end
    wq.push_back('{addr: 10'd11, parent: 32'd2, active: 1'b1});
    uq.push_back('{nodeid: 32'd11, level: 32'd2});
    exp_msgs++;
    bus.upd_ack = 1'b1;
    @(negedge sys_clk);
    n_checks++;
    if (bus.msg_ack !== 1'b0 || bus.rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_ackcycle: got msg_ack=%b rd_en=%b, required 0/0",
               bus.msg_ack, bus.rd_en);
    end
    @(posedge sys_clk); #1;
    bus.upd_ack = 1'b0;
    @(negedge sys_clk);
    n_checks++;
    if (bus.msg_ack !== 1'b1 || bus.rd_en !== 1'b1 || bus.rd_addr !== 10'd11) begin
      n_fail++;
      $display("FAIL hold_pending: got ack=%b rd_en=%b addr=%0d, required 1/1/11",
               bus.msg_ack, bus.rd_en, bus.rd_addr);
    end
    @(posedge sys_clk); #1;
    bus.msg_valid = 1'b0;
    finish_msg();
  endtask

  task automatic test_level_wrap();
    mem_parent[20] = '0;
    mem_active[20] = 1'b0;
    uq.push_back('{nodeid: 32'd20, level: 32'd0});
    wq.push_back('{addr: 10'd20, parent: 32'd8, active: 1'b1});
    exp_msgs++;
    do_msg(32'd2000, 32'd1, 32'd1);
    drive_msg(32'd20, 32'd8, 32'hFFFF_FFFF);
    @(posedge sys_clk); #1;
    bus.msg_valid = 1'b0;
    finish_msg();
    n_checks++;
    if (bus.upd_level !== 32'd0) begin
      n_fail++;
      $display("FAIL level_wrap: got upd_level=%0d, required 0", bus.upd_level);
    end
  endtask

  task automatic test_back_to_back();
    logic [NW-1:0] node;
    for (int i = 0; i < 9; i++) begin
      node = (i % 3 == 2) ? NW'(1024 + $urandom_range(0, 50)) : NW'($urandom_range(100, 104));
      do_msg(node, NW'($urandom_range(1, 1000)), LW'($urandom_range(0, 100)));
    end
    @(negedge sys_clk);
    n_checks++;
    if (bus.cnt_msgs !== 32'(exp_msgs) || bus.cnt_dropped !== 32'(exp_drops)) begin
      n_fail++;
      $display("FAIL b2b_counts: got msgs=%0d dropped=%0d, required %0d/%0d",
               bus.cnt_msgs, bus.cnt_dropped, exp_msgs, exp_drops);
    end
    @(posedge sys_clk); #1;
  endtask

  task automatic test_reset_abort();
    mem_parent[30] = '0;
    mem_active[30] = 1'b0;
    drive_msg(32'd30, 32'd5, 32'd5);
    @(negedge sys_clk);
    n_checks++;
    if (bus.rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_read: got rd_en=%b, required 1", bus.rd_en);
    end
    @(posedge sys_clk); #1;
    bus.msg_valid = 1'b0;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    n_checks++;
    if ({bus.wr_en, bus.busy, bus.msg_ack} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_in_reset: got wr/busy/ack=%b, required 000",
               {bus.wr_en, bus.busy, bus.msg_ack});
    end
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    exp_msgs = 0;
    exp_drops = 0;
    @(negedge sys_clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.msg_ack !== 1'b1 || bus.cnt_msgs !== '0 ||
        bus.cnt_dropped !== '0) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%b ack=%b msgs=%0d dropped=%0d, required 0/1/0/0",
               bus.busy, bus.msg_ack, bus.cnt_msgs, bus.cnt_dropped);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      n_checks++;
      if (bus.wr_en !== 1'b0 || bus.upd_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_quiet_%0d: got wr_en=%b upd_valid=%b, required 0/0",
                 i, bus.wr_en, bus.upd_valid);
      end
    end
    @(posedge sys_clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NN; i++) begin
      mem_parent[i] = '0;
      mem_active[i] = 1'b0;
    end
    sys_rst        = 1'b1;
    bus.msg_valid  = 1'b0;
    bus.msg_nodeid = '0;
    bus.msg_sender = '0;
    bus.msg_level  = '0;
    bus.upd_ack    = 1'b0;
    @(posedge sys_clk); #1;

    test_reset();
    test_first_visit();
    test_revisit();
    test_drop();
    test_emit_hold();
    test_level_wrap();
    test_back_to_back();
    test_reset_abort();

    n_checks++;
    if (wq.size() != 0 || uq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d writes and %0d updates outstanding, required 0/0",
               wq.size(), uq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
